// File: rtl/memory_stream_reader.sv
// Streams a block of words out of a memory read port onto a valid/ready interface.
// A 4-entry credit-managed buffer hides the memory's one-cycle read latency and downstream stalls.
module memory_stream_reader #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 512,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_read_enable,
   output logic [ADDR_WIDTH-1:0] mem_read_addr,
   input  logic [WIDTH-1:0]      mem_read_data,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned LEN_W       = ADDR_WIDTH + 1;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned PTR_W       = 2;
   localparam int unsigned BUF_ENTRIES = 4;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [LEN_W-1:0]        remaining;
   logic [LEN_W-1:0]        pending;
   logic                    data_vld;

   // The output register is the buffer head; the FIFO holds the entries behind it.
   logic [WIDTH-1:0]        fifo_mem [BUF_ENTRIES];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        fifo_cnt;

   logic                    handshake_c;
   logic [CNT_W-1:0]        occupancy_c;
   logic [CNT_W-1:0]        in_flight_c;
   logic                    issue_c;
   logic                    bypass_c;
   logic                    push_c;
   logic                    pop_c;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
      return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   // Credit check: buffered words plus outstanding reads never exceed the buffer size.
   always_comb begin
      handshake_c = out_valid & out_ready;
      occupancy_c = fifo_cnt + CNT_W'(out_valid);
      in_flight_c = CNT_W'(mem_read_enable) + CNT_W'(data_vld);
      issue_c     = (state == STREAM) && (remaining != '0) &&
                    ((occupancy_c + in_flight_c) < CNT_W'(BUF_ENTRIES));
      bypass_c    = data_vld && (fifo_cnt == '0) && (!out_valid || handshake_c);
      push_c      = data_vld && !bypass_c;
      pop_c       = handshake_c && (fifo_cnt != '0);
   end

   always_ff @(posedge clock) begin
      if (push_c) fifo_mem[wr_ptr] <= mem_read_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         addr            <= '0;
         remaining       <= '0;
         pending         <= '0;
         data_vld        <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_cnt        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         mem_read_enable <= 1'b0;
         mem_read_addr   <= '0;
         out_data        <= '0;
         out_valid       <= 1'b0;
      end else if (abort) begin
         // Read data still in flight is dropped by clearing data_vld.
         state           <= IDLE;
         remaining       <= '0;
         pending         <= '0;
         data_vld        <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_cnt        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         mem_read_enable <= 1'b0;
         out_valid       <= 1'b0;
      end else begin
         done            <= 1'b0;
         mem_read_enable <= 1'b0;
         data_vld        <= mem_read_enable;

         if (pop_c) begin
            out_data  <= fifo_mem[rd_ptr];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + PTR_W'(1);
         end else if (bypass_c) begin
            out_data  <= mem_read_data;
            out_valid <= 1'b1;
         end else if (handshake_c) begin
            out_valid <= 1'b0;
         end
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);

         if (handshake_c) pending <= pending - LEN_W'(1);

         if (issue_c) begin
            mem_read_enable <= 1'b1;
            mem_read_addr   <= addr;
            addr            <= next_addr(addr);
            remaining       <= remaining - LEN_W'(1);
         end

         case (state)
            IDLE: begin
               // First read issues on the start edge to meet the startup latency.
               if (start) begin
                  if (length == '0) begin
                     done <= 1'b1;
                  end else begin
                     mem_read_enable <= 1'b1;
                     mem_read_addr   <= start_addr;
                     addr            <= next_addr(start_addr);
                     remaining       <= length - LEN_W'(1);
                     pending         <= length;
                     busy            <= 1'b1;
                     state           <= (length == LEN_W'(1)) ? DRAIN : STREAM;
                  end
               end
            end
            STREAM: begin
               if (issue_c && (remaining == LEN_W'(1))) state <= DRAIN;
            end
            DRAIN: begin
               if (handshake_c && (pending == LEN_W'(1))) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Scoreboard bench for memory_stream_reader with a behavioural one-cycle-latency memory
// preloaded with mem[a] = a[7:0].
module tb_memory_stream_reader;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned DEPTH      = 512;
   localparam int unsigned ADDR_WIDTH = 9;

   logic                  clock;
   logic                  reset_n;
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic                  mem_read_enable;
   logic [ADDR_WIDTH-1:0] mem_read_addr;
   logic [WIDTH-1:0]      mem_read_data;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;

   logic [WIDTH-1:0]      mem [DEPTH];

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0]      exp_q [$];
   logic [ADDR_WIDTH-1:0] addr_q [$];
   int   hs_count = 0;
   bit   track_en = 1'b0;
   int   issued = 0;
   int   delivered = 0;
   bit   prev_stall = 1'b0;
   logic [WIDTH-1:0] held_data = '0;
   int   n;

   memory_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .start_addr      (start_addr),
      .length          (length),
      .abort           (abort),
      .busy            (busy),
      .done            (done),
      .mem_read_enable (mem_read_enable),
      .mem_read_addr   (mem_read_addr),
      .mem_read_data   (mem_read_data),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always_ff @(posedge clock) begin
      if (mem_read_enable) mem_read_data <= mem[mem_read_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle observation at the falling edge: read addresses, stream data, stall hold, credits.
   task automatic monitor();
      if (track_en) begin
         if (mem_read_enable) issued++;
         check("outstanding_le4", 32'((issued - delivered) <= 4), 32'(1));
      end
      if (prev_stall) begin
         check("hold_valid", 32'(out_valid), 32'(1));
         check("hold_data", 32'(out_data), 32'(held_data));
      end
      if (mem_read_enable) begin
         if (addr_q.size() != 0) check("rd_addr", 32'(mem_read_addr), 32'(addr_q.pop_front()));
         else check("rd_unexpected", 32'(mem_read_enable), 32'(0));
      end
      if (out_valid && out_ready) begin
         hs_count++;
         if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
         else check("sb_underflow", 32'(out_valid), 32'(0));
         if (track_en) delivered++;
      end
      prev_stall = out_valid && !out_ready && !abort && reset_n;
      held_data  = out_data;
   endtask

   task automatic tick();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
   endtask

   task automatic start_xfer(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH:0] len,
                             input bit expect_it);
      start_addr = a;
      length     = len;
      start      = 1'b1;
      if (expect_it) begin
         for (int i = 0; i < int'(len); i++) begin
            logic [ADDR_WIDTH-1:0] ai;
            ai = ADDR_WIDTH'((int'(a) + i) % DEPTH);
            addr_q.push_back(ai);
            exp_q.push_back(WIDTH'(ai));
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output int cycles);
      cycles = 0;
      while (!done && cycles < max_cycles) begin
         tick();
         cycles++;
      end
      check("done_seen", 32'(done), 32'(1));
      check("busy_at_done", 32'(busy), 32'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_done"}, 32'(done), 32'(0));
      check({tag, "_mre"}, 32'(mem_read_enable), 32'(0));
      check({tag, "_maddr"}, 32'(mem_read_addr), 32'(0));
      check({tag, "_odata"}, 32'(out_data), 32'(0));
      check({tag, "_ovalid"}, 32'(out_valid), 32'(0));
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_exp_left"}, 32'(exp_q.size()), 32'(0));
      check({tag, "_addr_left"}, 32'(addr_q.size()), 32'(0));
   endtask

   initial begin
      for (int a = 0; a < int'(DEPTH); a++) mem[a] = WIDTH'(a);
      reset_n    = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      length     = '0;
      abort      = 1'b0;
      out_ready  = 1'b0;

      #12;
      check_all_zero("reset");
      @(posedge clock);
      #1 reset_n = 1'b1;
      tick();

      // Basic block with exact startup latency and done timing.
      out_ready = 1'b1;
      start_xfer(10, 4, 1'b1);
      check("t1_mre_t1", 32'(mem_read_enable), 32'(1));
      check("t1_addr_t1", 32'(mem_read_addr), 32'(10));
      check("t1_busy_t1", 32'(busy), 32'(1));
      check("t1_ovalid_t1", 32'(out_valid), 32'(0));
      tick();
      check("t1_ovalid_t2", 32'(out_valid), 32'(0));
      tick();
      check("t1_ovalid_t3", 32'(out_valid), 32'(1));
      check("t1_data_t3", 32'(out_data), 32'(10));
      wait_done(20, n);
      check("t1_done_latency", 32'(n), 32'(4));
      tick();
      check("t1_done_pulse", 32'(done), 32'(0));
      check_drained("t1");

      // Address wrap at the top of memory.
      start_xfer(510, 4, 1'b1);
      wait_done(20, n);
      tick();
      check_drained("t2");

      // Random backpressure with a long stall stretch.
      issued    = 0;
      delivered = 0;
      track_en  = 1'b1;
      start_xfer(100, 16, 1'b1);
      for (int k = 0; k < 400; k++) begin
         out_ready = (k >= 6 && k < 16) ? 1'b0 : 1'($urandom_range(0, 1));
         tick();
         if (done) break;
      end
      track_en = 1'b0;
      check("t3_done", 32'(done), 32'(1));
      check("t3_delivered", 32'(delivered), 32'(16));
      out_ready = 1'b1;
      tick();
      check_drained("t3");

      // Zero-length start.
      start_xfer(5, 0, 1'b0);
      check("t4_done", 32'(done), 32'(1));
      check("t4_busy", 32'(busy), 32'(0));
      check("t4_mre", 32'(mem_read_enable), 32'(0));
      tick();
      check("t4_done_drop", 32'(done), 32'(0));
      check("t4_busy2", 32'(busy), 32'(0));
      check("t4_mre2", 32'(mem_read_enable), 32'(0));

      // Abort after two handshakes, then a clean follow-up transfer.
      hs_count = 0;
      start_xfer(200, 8, 1'b1);
      for (int k = 0; k < 30 && hs_count < 2; k++) tick();
      check("t5_two_hs", 32'(hs_count), 32'(2));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      addr_q.delete();
      check("t5_busy", 32'(busy), 32'(0));
      check("t5_ovalid", 32'(out_valid), 32'(0));
      check("t5_mre", 32'(mem_read_enable), 32'(0));
      check("t5_done", 32'(done), 32'(0));
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t5_no_done", 32'(done), 32'(0));
         check("t5_idle_valid", 32'(out_valid), 32'(0));
      end
      start_xfer(0, 2, 1'b1);
      wait_done(20, n);
      tick();
      check_drained("t5");

      // Asynchronous reset mid-stream, away from a clock edge.
      start_xfer(300, 16, 1'b1);
      repeat (5) tick();
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("t6_rst");
      exp_q.delete();
      addr_q.delete();
      prev_stall = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Start while busy is ignored.
      out_ready = 1'b0;
      start_xfer(50, 6, 1'b1);
      repeat (3) tick();
      start_xfer(300, 3, 1'b0);
      check("t7_busy_held", 32'(busy), 32'(1));
      out_ready = 1'b1;
      wait_done(40, n);
      repeat (5) tick();
      check_drained("t7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
